key_detect: RTL

Per-frame finger detector for the on-screen keyboard. Consumes the camera pixel stream (`addr`, 9-bit RGB333 color), classifies each pixel with `isfinger`, and counts finger pixels per 8-pixel-wide key column inside the keyboard zone. At each frame end it thresholds the counts and debounces them across frames. It drives the `key_down` vector consumed by the UI overlay and by the note generator.

---
 rtl/capiano_pkg.sv | 18 +
 rtl/isfinger.sv | 24 ++
 rtl/key_detect.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/capiano_pkg.sv
// Shared constants and types for the camera-piano datapath.
// Key geometry, detection-zone rows and the RGB333 pixel type.
package capiano_pkg;

  localparam int NUM_KEYS   = 39;
  localparam int KEY_W_LOG2 = 3;
  localparam int ZONE_Y_MIN = 321;
  localparam int ZONE_Y_MAX = 479;

  typedef logic [8:0] rgb333_t;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EVAL  = 2'd2
  } kd_state_e;

endpackage

// File: rtl/isfinger.sv
// Combinational skin-tone classifier for one RGB333 pixel.
// Ports: q = pixel colour in, is_finger = classification out.
module isfinger
  import capiano_pkg::*;
(
  input  rgb333_t q,
  output logic    is_finger
);

  logic [2:0] r;
  logic [2:0] g;
  logic [2:0] b;

  assign r = q[8:6];
  assign g = q[5:3];
  assign b = q[2:0];

  // Strong red, moderate green, weak blue.
  assign is_finger = (r >= 3'd5) &&
                     (g >= 3'd2) &&
                     (g <= 3'd4) &&
                     (b <= 3'd3);

endmodule

// File: rtl/key_detect.sv
// Per-frame finger detector: counts finger pixels per key column,
// thresholds and debounces them at frame end into key_down.
// Ports: clk, rst_n (sync, active-low), pix_valid/addr/color pixel
// stream, frame_end pulse; key_down, key_update pulse, busy.
module key_detect #(
  parameter int NUM_KEYS   = capiano_pkg::NUM_KEYS,
  parameter int ZONE_Y_MIN = capiano_pkg::ZONE_Y_MIN,
  parameter int ZONE_Y_MAX = capiano_pkg::ZONE_Y_MAX,
  parameter int HIT_THRESH = 16,
  parameter int DEB_FRAMES = 2,
  parameter int CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  input  logic [31:0]           addr,
  input  capiano_pkg::rgb333_t  color,
  input  logic                  frame_end,
  output logic [NUM_KEYS:0]     key_down,
  output logic                  key_update,
  output logic                  busy
);

  import capiano_pkg::*;

  localparam int NK    = NUM_KEYS + 1;
  localparam int KID_W = $clog2(NK);

  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic [15:0] key_full;
  logic        in_zone;
  logic        in_range;
  logic        finger;

  kd_state_e         state_q, state_d;
  logic              hit_q, hit_d;
  logic [KID_W-1:0]  key_q, key_d;
  logic [CNT_W-1:0]  cnt_q [NK];
  logic [CNT_W-1:0]  cnt_d [NK];
  logic [1:0]        deb_q [NK];
  logic [1:0]        deb_d [NK];
  logic [NK-1:0]     raw;
  logic [NK-1:0]     key_down_q, key_down_d;
  logic              key_update_q, key_update_d;
  logic              busy_q, busy_d;

  assign pix_y    = addr[31:16];
  assign pix_x    = addr[15:0];
  assign key_full = pix_x >> KEY_W_LOG2;

  assign in_zone  = (pix_y >= 16'(ZONE_Y_MIN)) &&
                    (pix_y <= 16'(ZONE_Y_MAX));
  assign in_range = (key_full <= 16'(NUM_KEYS));

  isfinger u_isfinger (
    .q         (color),
    .is_finger (finger)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM: if (frame_end) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_EVAL;
      ST_EVAL:  state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  // Stage 1: only pixels arriving in ACCUM (incl. the frame_end
  // cycle) can produce a hit.
  always_comb begin
    hit_d = pix_valid && in_zone && finger && in_range &&
            (state_q == ST_ACCUM);
    key_d = key_full[KID_W-1:0];
  end

  always_comb begin
    for (int k = 0; k < NK; k++) begin
      raw[k] = (cnt_q[k] >= CNT_W'(HIT_THRESH));
    end
  end

  // Stage 2 counters and EVAL-time debounce.
  always_comb begin
    key_down_d = key_down_q;
    for (int k = 0; k < NK; k++) begin
      cnt_d[k] = cnt_q[k];
      deb_d[k] = deb_q[k];
      if (state_q == ST_EVAL) begin
        cnt_d[k] = '0;
        if (raw[k] == key_down_q[k]) begin
          deb_d[k] = 2'd0;
        end else if (({1'b0, deb_q[k]} + 3'd1) == 3'(DEB_FRAMES)) begin
          key_down_d[k] = ~key_down_q[k];
          deb_d[k]      = 2'd0;
        end else begin
          deb_d[k] = deb_q[k] + 2'd1;
        end
      end else if (hit_q && (key_q == KID_W'(k)) &&
                   (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
    key_update_d = (state_q == ST_EVAL);
    busy_d       = (state_d != ST_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ACCUM;
      hit_q        <= 1'b0;
      key_q        <= '0;
      key_down_q   <= '0;
      key_update_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int k = 0; k < NK; k++) begin
        cnt_q[k] <= '0;
        deb_q[k] <= 2'd0;
      end
    end else begin
      state_q      <= state_d;
      hit_q        <= hit_d;
      key_q        <= key_d;
      key_down_q   <= key_down_d;
      key_update_q <= key_update_d;
      busy_q       <= busy_d;
      for (int k = 0; k < NK; k++) begin
        cnt_q[k] <= cnt_d[k];
        deb_q[k] <= deb_d[k];
      end
    end
  end

  assign key_down   = key_down_q;
  assign key_update = key_update_q;
  assign busy       = busy_q;

endmodule
